cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Miss-fill sequencer for the 2-way, 64-set, 8-word-per-block L1 data array. On a lookup miss it issues eight pipelined 16-bit reads to memory, writes each returned word into the victim way, then pulses the tag-write strobe and `fill_done`. It sits between the cache lookup logic, the memory port and the data array's write/enable inputs. While `fill_busy` is high, the top-level mux selects this block's enables and data over the lookup path.

## Interface
- `DATA_W`, 16, word width; memory data and data-array data width.
- `ADDR_W`, 16, byte-address width. Field split is fixed: offset [3:0], word [3:1], set [9:4], tag [15:10].
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low. Sampled at the rising edge of `clk`.
- `miss_detected`  in  1  lookup missed; sampled only in IDLE.
- `miss_addr`  in  16  byte address of the missing access; latched with the miss.
- `victim_way`  in  1  way chosen by the replacement logic; latched with the miss.
- `mem_en`  out  1  memory read request, one word per cycle.
- `mem_wr`  out  1  memory write strobe; always 0 from this block.
- `mem_addr`  out  16  request byte address; bit 0 is always 0.
- `mem_data_valid`  in  1  returned word valid this cycle.
- `mem_data_in`  in  16  returned word.
- `da_data`  out  16  data-array write data; equals `mem_data_in`.
- `da_write`, `da_write2`  out  1 each  write strobe for way 0 and way 1.
- `da_block_en`, `da_block_en2`  out  64 each  one-hot set enable for way 0 and way 1.
- `da_word_en`  out  8  one-hot word enable.
- `tag_write`, `tag_write2`  out  1 each  tag/valid write for way 0 and way 1.
- `fill_busy`  out  1  high in FILL and DONE.
- `fill_done`  out  1  one-cycle pulse in DONE.
- `crit_valid`  out  1  the missed word is being written this cycle (early restart).

## Operation
States:
- IDLE
  - `miss_detected`=1: latch set, tag, missed word index, `victim_way`; clear `issue_cnt`/`recv_cnt`; go to FILL.
  - Otherwise stay in IDLE.
- FILL
  - Issue phase: while `issue_cnt`<8, `mem_en`=1 and `mem_addr`={tag, set, issue_word, 1'b0}; `issue_cnt` increments every cycle.
  - Receive phase: each cycle with `mem_data_valid`=1 and `recv_cnt`<8, write `mem_data_in` to word `recv_word` of the latched set in the victim way, then increment `recv_cnt`.
  - Write enables are combinational from `mem_data_valid`. Only the victim way's `da_write*` and `da_block_en*` are asserted. The other way's enables and strobe stay 0.
  - When `recv_cnt` reaches 8, go to DONE.
- DONE (one cycle): `fill_done`=1; victim way's `tag_write*`=1; go to IDLE.

Word order:
- `issue_word` = (start + `issue_cnt`) mod 8.
- `recv_word` = (start + `recv_cnt`) mod 8.
- start is set by the configuration macro.

Rules:
- Memory returns data in request order; `recv_cnt` alone tracks the returned words.
- `crit_valid`=1 when a write is in progress and `recv_word` equals the missed word index.
- Enables and strobes are 0 whenever no write is in progress.
- `mem_data_valid` is ignored in IDLE and DONE, and ignored once `recv_cnt`=8.
- `miss_detected` is ignored in FILL and DONE. No queueing: the requester must hold it until `fill_done`.
- Reset value of every output is 0. Registered state: IDLE, counters 0, latches 0.
- Reset mid-fill: IDLE on the next edge. Words already written stay in the array; tags are not written.

## Timing
- Miss accepted at edge T (IDLE).
- `fill_busy`=1 and `mem_en`=1 in cycles T+1 through T+8: eight back-to-back requests, no bubbles.
- Assume the memory has latency L and returns words on consecutive cycles.
  - Data-array writes occur in cycles T+1+L through T+8+L.
  - DONE is in cycle T+9+L; IDLE resumes in T+10+L.
- Gaps in `mem_data_valid` extend FILL one cycle per gap. The issue schedule is unaffected.
- A new miss is accepted no earlier than the first IDLE cycle after DONE.

## Configuration
- `CACHE_CRIT_WORD_FIRST_EN` defined:
  - start = missed word index; issue and receive order wrap 7→0.
  - `crit_valid` asserts on the first returned word.
- Undefined:
  - start = 0; order is 0..7.
  - `crit_valid` asserts when word `recv_cnt` equals the missed index.

## Structure
- Shared package `cache_pkg`:
  - localparams for offset/word/set/tag bit ranges, `NUM_SETS`=64, `WORDS_PER_BLOCK`=8.
  - FSM state type (IDLE, FILL, DONE).
- One sub-module, `fill_word_ctr`: 4-bit saturating-at-8 counter with a 3-bit start offset. It outputs `cnt`, `word` = (start+cnt) mod 8, and `done`. It is instantiated twice, once for issue and once for receive.

## Test plan
- Miss at `miss_addr`=0x1230, `victim_way`=0, L=4, macro off:
  - `mem_addr` 0x1230..0x123E over 8 cycles.
  - `da_block_en` bit 35, `da_word_en` 0x01..0x80.
  - `tag_write`=1 and `fill_done` at T+13.
- Same miss, `victim_way`=1:
  - only `da_write2`, `da_block_en2`, `tag_write2` active.
  - `da_block_en`=0 throughout.
- Macro on, `miss_addr`=0x1234:
  - requests 0x1234, 0x1236, …, 0x123E, 0x1230, 0x1232.
  - `crit_valid` on the first valid, with `da_word_en`=0x04.
- `mem_data_valid` with two one-cycle gaps: still exactly 8 writes; DONE delayed by 2 cycles.
- `rst`=0 at T+6: all outputs 0 at T+7. Later `mem_data_valid` pulses produce no writes. A new miss is accepted next.
- `miss_detected` held high through a fill: exactly one fill per assertion window. A second miss is accepted only at IDLE, at T+10+L.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared field layout and FSM state type for the L1 miss-fill sequencer.
// Address split: offset [3:0], word [3:1], set [9:4], tag [15:10].
package cache_pkg;

    localparam int OFF_LSB         = 0;
    localparam int OFF_MSB         = 3;
    localparam int WORD_LSB        = 1;
    localparam int WORD_MSB        = 3;
    localparam int SET_LSB         = 4;
    localparam int SET_MSB         = 9;
    localparam int TAG_LSB         = 10;
    localparam int TAG_MSB         = 15;
    localparam int NUM_SETS        = 64;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_W          = WORD_MSB - WORD_LSB + 1;
    localparam int SET_W           = SET_MSB - SET_LSB + 1;
    localparam int TAG_W           = TAG_MSB - TAG_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } fill_state_t;

endpackage

// File: rtl/fill_word_ctr.sv
// Word counter for a block fill: counts 0..8 (saturating) and maps the count
// onto a word index rotated by a 3-bit start offset.
module fill_word_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] start,
    output logic [3:0] cnt,
    output logic [2:0] word,
    output logic       done
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !cnt[3]) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign word = start + cnt[2:0];
    assign done = cnt[3];

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-fill sequencer: issues eight pipelined word reads and writes the returned
// words into the victim way. CACHE_CRIT_WORD_FIRST_EN selects critical-word-first order.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_detected,
    input  logic [ADDR_W-1:0]   miss_addr,
    input  logic                victim_way,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_data_valid,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic [DATA_W-1:0]   da_data,
    output logic                da_write,
    output logic                da_write2,
    output logic [NUM_SETS-1:0] da_block_en,
    output logic [NUM_SETS-1:0] da_block_en2,
    output logic [WORDS_PER_BLOCK-1:0] da_word_en,
    output logic                tag_write,
    output logic                tag_write2,
    output logic                fill_busy,
    output logic                fill_done,
    output logic                crit_valid
);

    fill_state_t       state;
    logic [SET_W-1:0]  set_q;
    logic [TAG_W-1:0]  tag_q;
    logic [WORD_W-1:0] crit_q;
    logic              way_q;
    logic [WORD_W-1:0] start;

    logic              accept;
    logic              in_fill;
    logic              wr_act;
    logic [3:0]        issue_cnt;
    logic [3:0]        recv_cnt;
    logic [2:0]        issue_word;
    logic [2:0]        recv_word;
    logic              issue_done;
    logic              recv_done;
    logic [NUM_SETS-1:0] set_oh;

`ifdef CACHE_CRIT_WORD_FIRST_EN
    assign start = crit_q;
`else
    assign start = '0;
`endif

    assign accept  = (state == ST_IDLE) && miss_detected;
    assign in_fill = (state == ST_FILL);
    assign wr_act  = in_fill && mem_data_valid && !recv_done;

    fill_word_ctr u_issue_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (in_fill && !issue_done),
        .start (start),
        .cnt   (issue_cnt),
        .word  (issue_word),
        .done  (issue_done)
    );

    fill_word_ctr u_recv_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .inc   (wr_act),
        .start (start),
        .cnt   (recv_cnt),
        .word  (recv_word),
        .done  (recv_done)
    );

    // Strobes and status are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            set_q      <= '0;
            tag_q      <= '0;
            crit_q     <= '0;
            way_q      <= 1'b0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
            tag_write  <= 1'b0;
            tag_write2 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        set_q     <= miss_addr[SET_MSB:SET_LSB];
                        tag_q     <= miss_addr[TAG_MSB:TAG_LSB];
                        crit_q    <= miss_addr[WORD_MSB:WORD_LSB];
                        way_q     <= victim_way;
                        fill_busy <= 1'b1;
                        state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (wr_act && (recv_cnt == 4'd7)) begin
                        fill_done  <= 1'b1;
                        tag_write  <= !way_q;
                        tag_write2 <= way_q;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fill_busy  <= 1'b0;
                    fill_done  <= 1'b0;
                    tag_write  <= 1'b0;
                    tag_write2 <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign set_oh = NUM_SETS'(1) << set_q;

    assign mem_en       = in_fill && (issue_cnt < 4'd8);
    assign mem_addr     = mem_en ? {tag_q, set_q, issue_word, 1'b0} : '0;
    assign mem_wr       = 1'b0;
    assign da_data      = mem_data_in;
    assign da_write     = wr_act && !way_q;
    assign da_write2    = wr_act && way_q;
    assign da_block_en  = da_write  ? set_oh : '0;
    assign da_block_en2 = da_write2 ? set_oh : '0;
    assign da_word_en   = wr_act ? (WORDS_PER_BLOCK'(1) << recv_word) : '0;
    assign crit_valid   = wr_act && (recv_word == crit_q);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl; expectations follow CACHE_CRIT_WORD_FIRST_EN
// when it is defined for the build.
module tb_cache_fill_ctrl;

    localparam int VW = 177;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_addr;
    logic        victim_way;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic [15:0] da_data;
    logic        da_write;
    logic        da_write2;
    logic [63:0] da_block_en;
    logic [63:0] da_block_en2;
    logic [7:0]  da_word_en;
    logic        tag_write;
    logic        tag_write2;
    logic        fill_busy;
    logic        fill_done;
    logic        crit_valid;

    logic [VW-1:0] obs;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_detected  (miss_detected),
        .miss_addr      (miss_addr),
        .victim_way     (victim_way),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data_in    (mem_data_in),
        .da_data        (da_data),
        .da_write       (da_write),
        .da_write2      (da_write2),
        .da_block_en    (da_block_en),
        .da_block_en2   (da_block_en2),
        .da_word_en     (da_word_en),
        .tag_write      (tag_write),
        .tag_write2     (tag_write2),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .crit_valid     (crit_valid)
    );

    always_comb begin
        obs = {mem_en, mem_wr, mem_addr, da_data, da_write, da_write2, da_block_en,
               da_block_en2, da_word_en, tag_write, tag_write2, fill_busy, fill_done, crit_valid};
    end

    function automatic logic [VW-1:0] mkvec(input logic en, input logic [15:0] addr,
                                            input logic [15:0] dd, input logic w0, input logic w1,
                                            input logic [63:0] b0, input logic [63:0] b1,
                                            input logic [7:0] we, input logic t0, input logic t1,
                                            input logic busy, input logic done, input logic crit);
        return {en, 1'b0, addr, dd, w0, w1, b0, b1, we, t0, t1, busy, done, crit};
    endfunction

    task automatic test_reset();
        rst            = 1'b0;
        miss_detected  = 1'b1;
        miss_addr      = 16'h1230;
        victim_way     = 1'b0;
        mem_data_valid = 1'b1;
        mem_data_in    = 16'h0000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        nvec++;
        if (obs !== '0) begin
            nerr++;
            $display("FAIL reset_hold: got %h want 0", obs);
        end
        rst            = 1'b1;
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        nvec++;
        if (obs !== '0) begin
            nerr++;
            $display("FAIL reset_release_idle: got %h want 0", obs);
        end
    endtask

    // One complete fill; gaps[w] inserts a one-cycle hole before returned word w.
    task automatic test_fill(input logic [15:0] addr, input logic way, input int lat,
                             input logic [7:0] gaps, input logic hold, input string name);
        logic [2:0]    s;
        logic [2:0]    crit;
        logic [2:0]    word;
        logic [VW-1:0] exp;
        logic          v;
        logic          wr;
        int            wcyc[8];
        int            c;
        int            c8;
        int            w;
        int            ngap;
        int            nwr;
        int            done_obs;
        crit = addr[3:1];
`ifdef CACHE_CRIT_WORD_FIRST_EN
        s = crit;
`else
        s = 3'd0;
`endif
        c    = 1 + lat;
        ngap = 0;
        for (int k = 0; k < 8; k++) begin
            if (gaps[k]) begin
                c++;
                ngap++;
            end
            wcyc[k] = c;
            c++;
        end
        c8 = wcyc[7];

        miss_addr      = addr;
        victim_way     = way;
        miss_detected  = 1'b1;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        @(posedge clk);
        #1;
        w        = 0;
        nwr      = 0;
        done_obs = -1;
        for (int cyc = 1; cyc <= c8 + 2; cyc++) begin
            if (!hold) miss_detected = 1'b0;
            v = 1'b0;
            if (w < 8) v = (cyc == wcyc[w]);
            if (cyc > c8) v = 1'b1;
            mem_data_valid = v;
            mem_data_in    = v ? (16'hA500 + 16'(cyc)) : 16'h0000;
            wr   = v && (cyc <= c8);
            word = s + w[2:0];
            exp  = mkvec(cyc <= 8,
                         (cyc <= 8) ? {addr[15:4], 3'(s + 3'(cyc - 1)), 1'b0} : 16'h0000,
                         mem_data_in,
                         wr && !way, wr && way,
                         (wr && !way) ? (64'd1 << addr[9:4]) : 64'd0,
                         (wr && way)  ? (64'd1 << addr[9:4]) : 64'd0,
                         wr ? (8'd1 << word) : 8'd0,
                         (cyc == c8 + 1) && !way, (cyc == c8 + 1) && way,
                         cyc <= c8 + 1, cyc == c8 + 1,
                         wr && (word == crit));
            @(negedge clk);
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL %s cyc %0d: got %h want %h", name, cyc, obs, exp);
            end
            if (da_write || da_write2) nwr++;
            if (fill_done) done_obs = cyc;
            if (wr) w++;
            if (cyc < c8 + 2) begin
                @(posedge clk);
                #1;
            end
        end
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        nvec++;
        if (nwr !== 8) begin
            nerr++;
            $display("FAIL %s write_count: got %0d want 8", name, nwr);
        end
        nvec++;
        if (done_obs !== 9 + lat + ngap) begin
            nerr++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_obs, 9 + lat + ngap);
        end
    endtask

    task automatic test_reset_midfill();
        miss_addr      = 16'h4C2A;
        victim_way     = 1'b1;
        miss_detected  = 1'b1;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
        @(posedge clk);
        #1;
        miss_detected = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            rst            = (cyc == 6) ? 1'b0 : 1'b1;
            mem_data_valid = (cyc >= 5);
            mem_data_in    = (cyc == 7) ? 16'h0000 : 16'h5A5A;
            @(negedge clk);
            if (cyc == 5) begin
                nvec++;
                if ({da_write, da_write2} !== 2'b01) begin
                    nerr++;
                    $display("FAIL midreset_prewrite: got %b want 01", {da_write, da_write2});
                end
            end
            if (cyc == 7) begin
                nvec++;
                if (obs !== '0) begin
                    nerr++;
                    $display("FAIL midreset_cleared: got %h want 0", obs);
                end
            end
            if (cyc > 7) begin
                nvec++;
                if (obs !== mkvec(1'b0, 16'h0, 16'h5A5A, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                    nerr++;
                    $display("FAIL midreset_stray_valid cyc %0d: got %h", cyc, obs);
                end
            end
            @(posedge clk);
            #1;
        end
        rst            = 1'b1;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;
    endtask

    initial begin
        rst            = 1'b0;
        miss_detected  = 1'b0;
        miss_addr      = 16'h0000;
        victim_way     = 1'b0;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'h0000;

        test_reset();
        test_fill(16'h1230, 1'b0, 4, 8'h00, 1'b0, "fill_way0");
        test_fill(16'h1230, 1'b1, 4, 8'h00, 1'b0, "fill_way1");
        test_fill(16'h1234, 1'b0, 2, 8'h00, 1'b0, "crit_word");
        test_fill(16'h0ABE, 1'b1, 3, 8'h24, 1'b0, "valid_gaps");
        test_reset_midfill();
        test_fill(16'h4C2A, 1'b1, 4, 8'h00, 1'b0, "after_reset");
        test_fill(16'h7FF0, 1'b0, 1, 8'h00, 1'b1, "held_miss_first");
        test_fill(16'h7FF0, 1'b0, 1, 8'h00, 1'b0, "held_miss_second");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
